// File: rtl/pipelined_norm_shifter.sv
// Two-stage valid/ready left shifter and normaliser for the FP add/sub path.
// Stage 1 picks the shift (explicit or leading-zero count), adjusts the
// exponent with a denormal clamp and flags zero/underflow. Stage 2 applies
// the shift with a logarithmic barrel shifter into the output registers.
// DataSize must be smaller than 2**ShiftBits so a shift of DataSize fits.
module pipelined_norm_shifter #(
  parameter int DataSize  = 25,
  parameter int ShiftBits = 5,
  parameter int ExpSize   = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [DataSize-1:0]  Mantissa,
  input  logic [ExpSize-1:0]   Exponent,
  input  logic                 Mode,
  input  logic [ShiftBits-1:0] Shifts,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [DataSize-1:0]  Aligned,
  output logic [ExpSize-1:0]   ExponentOut,
  output logic [ShiftBits-1:0] ShiftApplied,
  output logic                 Zero,
  output logic                 Underflow
);

  // Wide enough to compare and subtract shift amounts and exponents unsigned.
  localparam int CmpW = ((ExpSize > ShiftBits) ? ExpSize : ShiftBits) + 1;
  localparam logic [ShiftBits-1:0] FullShift = ShiftBits'(DataSize);

  // Leading-zero count; an all-zero word counts as DataSize.
  function automatic logic [ShiftBits-1:0] lzc(input logic [DataSize-1:0] v);
    logic [ShiftBits-1:0] n;
    n = FullShift;
    for (int i = 0; i < DataSize; i++) begin
      if (v[i]) n = ShiftBits'(DataSize - 1 - i);
    end
    return n;
  endfunction

  // Handshake
  logic s1_valid;
  logic s1_take;
  logic s2_take;

  assign s2_take = !OutValid || OutReady;
  assign s1_take = !s1_valid || s2_take;
  assign InReady = s1_take;

  // Stage-1 decision signals
  logic                 d_zero;
  logic                 d_uf;
  logic [ShiftBits-1:0] d_raw;
  logic [ShiftBits-1:0] d_shift;
  logic [ExpSize-1:0]   d_exp;

  // Stage-1 registers
  logic [DataSize-1:0]  s1_mant;
  logic [ShiftBits-1:0] s1_shift;
  logic [ExpSize-1:0]   s1_exp;
  logic                 s1_zero;
  logic                 s1_uf;

  // Choose the shift amount, adjusted exponent and flags for the incoming beat.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can leave a latch.
    d_zero  = (Mantissa == '0);
    d_raw   = Mode ? lzc(Mantissa) : Shifts;
    d_uf    = 1'b0;
    d_shift = '0;
    d_exp   = '0;
    if (!d_zero) begin
      d_uf = CmpW'(d_raw) > CmpW'(Exponent);
      if (Mode) begin
        // Normalising past the exponent floor yields a denormal: stop at Exponent.
        d_shift = d_uf ? ShiftBits'(Exponent) : d_raw;
      end else begin
        // Explicit shifts of DataSize or more flush the mantissa completely.
        d_shift = (CmpW'(d_raw) >= CmpW'(DataSize)) ? FullShift : d_raw;
      end
      if (!d_uf) d_exp = ExpSize'(CmpW'(Exponent) - CmpW'(d_shift));
    end
  end

  // Stage-1 valid flag advances whenever the stage can take a new beat.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (Reset) begin
      s1_valid <= 1'b0;
    end else if (s1_take) begin
      s1_valid <= InValid;
    end
  end

  // Stage-1 payload capture on an accepted beat.
  always_ff @(posedge Clk) begin
    // NOTE: the payload is qualified by s1_valid, so it is deliberately left without reset.
    if (s1_take && InValid) begin
      s1_mant  <= Mantissa;
      s1_shift <= d_shift;
      s1_exp   <= d_exp;
      s1_zero  <= d_zero;
      s1_uf    <= d_uf;
    end
  end

  // Logarithmic barrel shifter: level k shifts by 2**k when bit k is set.
  logic [DataSize-1:0] lvl [ShiftBits+1];

  assign lvl[0] = s1_mant;

  for (genvar k = 0; k < ShiftBits; k++) begin : g_lvl
    localparam int Step = 1 << k;
    if (Step >= DataSize) begin : g_flush
      assign lvl[k+1] = s1_shift[k] ? '0 : lvl[k];
    end else begin : g_shift
      assign lvl[k+1] = s1_shift[k] ? {lvl[k][DataSize-1-Step:0], {Step{1'b0}}} : lvl[k];
    end
  end

  // Output registers: load the shifted result when stage 2 can advance, hold otherwise.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      OutValid     <= 1'b0;
      Aligned      <= '0;
      ExponentOut  <= '0;
      ShiftApplied <= '0;
      Zero         <= 1'b0;
      Underflow    <= 1'b0;
    end else if (s2_take) begin
      OutValid <= s1_valid;
      if (s1_valid) begin
        Aligned      <= lvl[ShiftBits];
        ExponentOut  <= s1_exp;
        ShiftApplied <= s1_shift;
        Zero         <= s1_zero;
        Underflow    <= s1_uf;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_norm_shifter.sv
// Self-checking bench for pipelined_norm_shifter: a queue-based reference
// model predicts every result, a negedge monitor compares each cycle, and
// directed sequences cover stall, reset-flush and the documented examples.
module tb_pipelined_norm_shifter;

  localparam int DS = 25;
  localparam int SB = 5;
  localparam int EW = 8;

  typedef struct {
    logic [DS-1:0] aligned;
    logic [EW-1:0] eo;
    logic [SB-1:0] sh;
    logic          zero;
    logic          uf;
    int            acc;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DS-1:0] mant;
  logic [EW-1:0] expo;
  logic          mode;
  logic [SB-1:0] shifts;
  logic          out_valid;
  logic          out_ready;
  logic [DS-1:0] aligned;
  logic [EW-1:0] exponent_out;
  logic [SB-1:0] shift_applied;
  logic          zero;
  logic          underflow;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   mon_en = 0;
  exp_t q[$];

  pipelined_norm_shifter #(.DataSize(DS), .ShiftBits(SB), .ExpSize(EW)) dut (
    .Clk(clk), .Reset(rst), .InValid(in_valid), .InReady(in_ready),
    .Mantissa(mant), .Exponent(expo), .Mode(mode), .Shifts(shifts),
    .OutValid(out_valid), .OutReady(out_ready), .Aligned(aligned),
    .ExponentOut(exponent_out), .ShiftApplied(shift_applied),
    .Zero(zero), .Underflow(underflow)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: what the result must be, computed with plain integer arithmetic.
  function automatic exp_t model(input logic m, input logic [DS-1:0] ma, input int e, input int s);
    exp_t r;
    int raw;
    int sh;
    bit uf;
    longint unsigned tmp;
    r.acc = 0;
    if (ma == '0) begin
      r.aligned = '0; r.eo = '0; r.sh = '0; r.zero = 1'b1; r.uf = 1'b0;
      return r;
    end
    raw = 0;
    if (m) begin
      while (!ma[DS-1-raw]) raw++;
    end else begin
      raw = s;
    end
    uf = raw > e;
    if (m) sh = uf ? e : raw;
    else   sh = (raw >= DS) ? DS : raw;
    tmp = longint'(ma) << sh;
    r.aligned = tmp[DS-1:0];
    r.eo      = uf ? 8'd0 : 8'(e - sh);
    r.sh      = 5'(sh);
    r.zero    = 1'b0;
    r.uf      = uf;
    return r;
  endfunction

  // Per-cycle compare against the model queue.
  always @(negedge clk) begin
    exp_t e;
    logic exp_ov;
    if (mon_en) begin
      if (rst) begin
        q.delete();
      end else begin
        check("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
        exp_ov = (q.size() > 0) && (q[0].acc + 2 <= cyc);
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        if (out_valid && q.size() > 0) begin
          check("aligned",       32'(aligned),       32'(q[0].aligned));
          check("exponent_out",  32'(exponent_out),  32'(q[0].eo));
          check("shift_applied", 32'(shift_applied), 32'(q[0].sh));
          check("zero",          32'(zero),          32'(q[0].zero));
          check("underflow",     32'(underflow),     32'(q[0].uf));
          if (out_ready) void'(q.pop_front());
        end
        if (in_valid && in_ready) begin
          e = model(mode, mant, int'(expo), int'(shifts));
          e.acc = cyc;
          q.push_back(e);
        end
      end
    end
  end

  task automatic send(input logic m, input logic [DS-1:0] ma, input logic [EW-1:0] e,
                      input logic [SB-1:0] s);
    bit done;
    done = 0;
    mode = m; mant = ma; expo = e; shifts = s; in_valid = 1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
    end
    if (!done) check("send_timeout", 32'(0), 32'(1));
    in_valid = 0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", 32'(q.size()), 32'(0));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_valid"},     32'(out_valid),     32'(0));
    check({tag, "_aligned"},       32'(aligned),       32'(0));
    check({tag, "_exponent_out"},  32'(exponent_out),  32'(0));
    check({tag, "_shift_applied"}, 32'(shift_applied), 32'(0));
    check({tag, "_zero"},          32'(zero),          32'(0));
    check({tag, "_underflow"},     32'(underflow),     32'(0));
    check({tag, "_in_ready"},      32'(in_ready),      32'(1));
  endtask

  initial begin
    exp_t r;
    int   k;
    int   ncons;
    bit   acc;
    logic [31:0] rnd;

    rst = 1; in_valid = 0; out_ready = 1; mode = 0; mant = '0; expo = '0; shifts = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0; mon_en = 1;
    @(negedge clk);
    check_cleared("reset");

    // Pin the model with hand-computed results.
    r = model(1'b1, 25'h0000100, 100, 0);
    check("pin1_aligned", 32'(r.aligned), 32'h1000000);
    check("pin1_shift",   32'(r.sh), 32'd16);
    check("pin1_exp",     32'(r.eo), 32'd84);
    check("pin1_uf",      32'(r.uf), 32'd0);
    r = model(1'b1, 25'h0000001, 10, 0);
    check("pin2_aligned", 32'(r.aligned), 32'h400);
    check("pin2_shift",   32'(r.sh), 32'd10);
    check("pin2_exp",     32'(r.eo), 32'd0);
    check("pin2_uf",      32'(r.uf), 32'd1);
    r = model(1'b0, 25'h1FFFFFF, 200, 30);
    check("pin3_aligned", 32'(r.aligned), 32'h0);
    check("pin3_shift",   32'(r.sh), 32'd25);
    check("pin3_exp",     32'(r.eo), 32'd175);
    r = model(1'b0, 25'h0, 50, 7);
    check("pin4_zero",    32'(r.zero), 32'd1);
    check("pin4_shift",   32'(r.sh), 32'd0);

    // Documented examples through the DUT, checked by the monitor.
    @(posedge clk); #1;
    send(1'b1, 25'h0000100, 8'd100, 5'd0);
    send(1'b1, 25'h0000001, 8'd10,  5'd0);
    send(1'b0, 25'h1FFFFFF, 8'd200, 5'd30);
    send(1'b1, 25'h0000000, 8'd50,  5'd0);
    send(1'b0, 25'h0000000, 8'd50,  5'd9);
    drain();

    // Back-to-back explicit shifts 1..4 of 0x1 with a three-cycle downstream stall.
    out_ready = 0; mode = 0; mant = 25'h1; expo = 8'd100; shifts = 5'd1; in_valid = 1;
    k = 0; ncons = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (c == 2) check("stall_accepts", 32'(k), 32'(2));
      if (c >= 2 && c <= 4) begin
        check("stall_in_ready",  32'(in_ready),  32'(0));
        check("stall_out_valid", 32'(out_valid), 32'(1));
        check("stall_aligned",   32'(aligned),   32'h2);
      end
      if (out_valid && out_ready) begin
        check("seq_value", 32'(aligned), 32'(2 << ncons));
        check("seq_cycle", 32'(c), 32'(5 + ncons));
        ncons++;
      end
      @(posedge clk); #1;
      if (acc) begin
        k++;
        if (k < 4) shifts = 5'(k + 1);
        else in_valid = 0;
      end
      if (c == 4) out_ready = 1;
    end
    check("seq_count", 32'(ncons), 32'(4));
    drain();

    // Reset with two beats in flight, then a fresh beat with latency 2.
    mode = 0; mant = 25'h3; expo = 8'd60; shifts = 5'd2; in_valid = 1;
    @(posedge clk); #1;
    shifts = 5'd3;
    @(posedge clk); #1;
    in_valid = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check_cleared("flush");
    @(posedge clk); #1;
    mode = 1; mant = 25'h40; expo = 8'd30; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    check("post_rst_lat1_valid", 32'(out_valid), 32'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_lat2_valid", 32'(out_valid),     32'(1));
    check("post_rst_aligned",    32'(aligned),       32'h1000000);
    check("post_rst_exp",        32'(exponent_out),  32'd12);
    check("post_rst_shift",      32'(shift_applied), 32'd18);
    drain();

    // Randomised traffic with random back-pressure and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      mode      = 1'($urandom_range(0, 1));
      rnd       = $urandom >> $urandom_range(0, 31);
      mant      = ($urandom_range(0, 9) == 0) ? '0 : rnd[DS-1:0];
      expo      = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 255));
      shifts    = 5'($urandom_range(0, 31));
      rst       = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #1;
    rst = 0; in_valid = 0; out_ready = 1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
